// File: rtl/freq_pkg.sv
// Shared constants, octave-8 note table and FSM state type for note_freq_engine.
// The optional pitch-bend stage is enabled by defining FREQ_BEND_EN.
package freq_pkg;

  localparam int NOTE_W     = 4;
  localparam int OCT_W      = 3;
  localparam int BEND_W     = 8;
  localparam int BEND_SHIFT = 11;
  localparam int TAB_W      = 29;
  localparam int TAB_FRAC   = 16;

  // C8..B8 in Q13.16 Hz; lower octaves come from right shifts of these.
  localparam logic [TAB_W-1:0] NOTE_TABLE [12] = '{
    29'd274334289,  // C8   4186.009 Hz
    29'd290647054,  // C#8  4434.922 Hz
    29'd307929828,  // D8   4698.636 Hz
    29'd326240288,  // D#8  4978.032 Hz
    29'd345639545,  // E8   5274.041 Hz
    29'd366192342,  // F8   5587.652 Hz
    29'd387967272,  // F#8  5919.911 Hz
    29'd411037005,  // G8   6271.927 Hz
    29'd435478539,  // G#8  6644.875 Hz
    29'd461373440,  // A8   7040.000 Hz
    29'd488808132,  // A#8  7458.620 Hz
    29'd517874177   // B8   7902.133 Hz
  };

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_BEND  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Out-of-range notes read as zero so the result is 0 Hz.
  function automatic logic [TAB_W-1:0] note_lookup(input logic [NOTE_W-1:0] note);
    if (note < 4'd12) return NOTE_TABLE[note];
    return '0;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first pending channel after the last-served one.
// Purely combinational; the caller owns the last-served pointer.
module rr_arbiter
  import freq_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int IDX_W    = 2
) (
  input  logic [CHANNELS-1:0] i_pending,
  input  logic [IDX_W-1:0]    i_last,
  output logic [CHANNELS-1:0] o_grant,
  output logic [IDX_W-1:0]    o_idx,
  output logic                o_valid
);

  int         w_c;
  logic [IDX_W-1:0] w_ci;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_c     = 0;
    w_ci    = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      w_c = int'(i_last) + i;
      if (w_c >= CHANNELS) w_c = w_c - CHANNELS;
      w_ci = IDX_W'(w_c);
      if (!o_valid && i_pending[w_ci]) begin
        o_valid       = 1'b1;
        o_idx         = w_ci;
        o_grant[w_ci] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/note_freq_engine.sv
// Multi-channel note-to-frequency engine: round-robin service, one-bit-per-cycle
// octave shifter, per-channel result hold. Define FREQ_BEND_EN for the pitch-bend stage.
module note_freq_engine
  import freq_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int FRAC_BITS = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [CHANNELS-1:0]                 req_i,
  input  logic [NOTE_W*CHANNELS-1:0]          note_i,
  input  logic [OCT_W*CHANNELS-1:0]           octave_i,
`ifdef FREQ_BEND_EN
  input  logic [BEND_W*CHANNELS-1:0]          bend_i,
`endif
  output logic [(13+FRAC_BITS)*CHANNELS-1:0]  freq_o,
  output logic [CHANNELS-1:0]                 done_o,
  output logic [CHANNELS-1:0]                 err_o,
  output logic [CHANNELS-1:0]                 busy_o,
  output logic [2:0]                          dbg_state_o
);

  localparam int WIDTH  = 13 + FRAC_BITS;
  localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int TAB_SH = TAB_FRAC - FRAC_BITS;

  // req_i is a fire-and-forget strobe with no ready: every request is accepted
  // into the channel slot, last write before grant wins; done_o marks the result.

  state_t                r_state, w_next;
  logic [CHANNELS-1:0]   r_pending;
  logic [NOTE_W-1:0]     r_note_slot [CHANNELS];
  logic [OCT_W-1:0]      r_oct_slot  [CHANNELS];
  logic [IDX_W-1:0]      r_last, r_gidx;
  logic [NOTE_W-1:0]     r_note;
  logic [OCT_W-1:0]      r_oct;
  logic [WIDTH-1:0]      r_acc;
  logic [3:0]            r_cnt;
  logic                  r_err;
  logic [WIDTH-1:0]      r_freq [CHANNELS];
  logic [CHANNELS-1:0]   r_done, r_err_o;

  logic [CHANNELS-1:0]   w_grant, w_clr;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_valid;

  rr_arbiter #(.CHANNELS(CHANNELS), .IDX_W(IDX_W)) u_arb (
    .i_pending (r_pending),
    .i_last    (r_last),
    .o_grant   (w_grant),
    .o_idx     (w_idx),
    .o_valid   (w_valid)
  );

  assign w_clr = (r_state == ST_IDLE && w_valid) ? w_grant : '0;

`ifdef FREQ_BEND_EN
  localparam int PW = WIDTH + 1 + BEND_W;
  logic signed [BEND_W-1:0] r_bend_slot [CHANNELS];
  logic signed [BEND_W-1:0] r_bend;
  logic signed [WIDTH:0]    w_acc_s;
  logic signed [PW-1:0]     w_prod, w_sum;
  logic [WIDTH-1:0]         w_bend_acc;

  assign w_acc_s = $signed({1'b0, r_acc});
  assign w_prod  = PW'(w_acc_s) * PW'(r_bend);
  assign w_sum   = PW'(w_acc_s) + (w_prod >>> BEND_SHIFT);

  always_comb begin
    w_bend_acc = w_sum[WIDTH-1:0];
    if (w_sum[PW-1])             w_bend_acc = '0;
    else if (|w_sum[PW-2:WIDTH]) w_bend_acc = '1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CHANNELS; c++) r_bend_slot[c] <= '0;
      r_bend <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++)
        if (req_i[c]) r_bend_slot[c] <= bend_i[c*BEND_W +: BEND_W];
      if (r_state == ST_IDLE && w_valid) r_bend <= r_bend_slot[w_idx];
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_valid) w_next = ST_LOAD;
      ST_LOAD:  w_next = ST_SHIFT;
      ST_SHIFT: if (r_cnt == 4'd1) begin
`ifdef FREQ_BEND_EN
        w_next = ST_BEND;
`else
        w_next = ST_DONE;
`endif
      end
      ST_BEND:  w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending <= '0;
      r_last    <= IDX_W'(CHANNELS - 1);
      r_gidx    <= '0;
      r_note    <= '0;
      r_oct     <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_done    <= '0;
      r_err_o   <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_note_slot[c] <= '0;
        r_oct_slot[c]  <= '0;
        r_freq[c]      <= '0;
      end
    end else begin
      r_done    <= '0;
      r_err_o   <= '0;
      // A request in the grant cycle re-arms pending after the clear.
      r_pending <= (r_pending & ~w_clr) | req_i;
      for (int c = 0; c < CHANNELS; c++) begin
        if (req_i[c]) begin
          r_note_slot[c] <= note_i[c*NOTE_W +: NOTE_W];
          r_oct_slot[c]  <= octave_i[c*OCT_W +: OCT_W];
        end
      end
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_gidx <= w_idx;
            r_last <= w_idx;
            r_note <= r_note_slot[w_idx];
            r_oct  <= r_oct_slot[w_idx];
          end
        end
        ST_LOAD: begin
          r_acc <= WIDTH'(note_lookup(r_note) >> TAB_SH);
          r_err <= (r_note > 4'd11);
          r_cnt <= 4'd8 - {1'b0, r_oct};
        end
        ST_SHIFT: begin
          r_acc <= r_acc >> 1;
          r_cnt <= r_cnt - 4'd1;
        end
`ifdef FREQ_BEND_EN
        ST_BEND: r_acc <= w_bend_acc;
`endif
        ST_DONE: begin
          r_freq[r_gidx]  <= r_acc;
          r_done[r_gidx]  <= 1'b1;
          r_err_o[r_gidx] <= r_err;
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_out
    assign freq_o[g*WIDTH +: WIDTH] = r_freq[g];
    assign busy_o[g] = r_pending[g] | ((r_state != ST_IDLE) && (r_gidx == IDX_W'(g)));
  end

  assign done_o      = r_done;
  assign err_o       = r_err_o;
  assign dbg_state_o = r_state;

endmodule

// File: doc/note_freq_engine.md
# note_freq_engine

Multi-channel note-to-frequency engine for the synth voice path. Each of CHANNELS voices posts a note (0..11, C..B) and octave (0..7). The block serves pending requests round-robin. Each result is a fixed-point frequency in Hz, computed from a 12-entry octave-8 table by an iterative one-bit-per-cycle right shift. Per-channel results are held for the oscillator/phase-accumulator stage downstream.

## Interface
- CHANNELS, 4, number of voices (1..16)
- FRAC_BITS, 8, fractional bits of result (0..16); WIDTH = 13+FRAC_BITS (localparam)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req_i  in  CHANNELS  per-channel request strobe, sampled each rising edge
- note_i  in  4*CHANNELS  note per channel, sampled with req_i
- octave_i  in  3*CHANNELS  octave per channel, sampled with req_i
- bend_i  in  8*CHANNELS  signed pitch bend per channel (FREQ_BEND_EN only)
- freq_o  out  WIDTH*CHANNELS  last result per channel, unsigned Q13.FRAC_BITS Hz
- done_o  out  CHANNELS  one-cycle pulse when freq_o[ch] updates
- err_o  out  CHANNELS  one-cycle pulse with done_o when note was > 11
- busy_o  out  CHANNELS  channel pending or in service

## Operation
- Request capture: req_i[ch]=1 sets pending[ch] and latches note/octave (and bend) into the channel slot. A repeat request before grant overwrites the slot (last wins). A request on the channel in service is captured as a new pending entry and does not disturb the current computation.
- FSM states:
  - IDLE: if any pending, the rr_arbiter grants the first pending channel after last-served, copies its slot to working registers and clears its pending bit -> LOAD.
  - LOAD: acc = NOTE_TABLE[note] >> (16-FRAC_BITS). Note > 11 loads 0 and sets the err flag. cnt = 8-octave -> SHIFT.
  - SHIFT: acc >>= 1, cnt--; on cnt reaching 0 -> BEND if FREQ_BEND_EN, else DONE.
  - DONE: freq_o[grant] = acc; done_o[grant] and err_o (if flagged) pulse -> IDLE.
- Shift is logical truncation, with no rounding.
- Only the granted channel's freq_o changes. Other channels hold their value.
- busy_o[ch] = pending[ch] | (state != IDLE && grant == ch).

## Timing
- Reset (asynchronous, any state):
  - freq_o, done_o, err_o, busy_o all 0.
  - Pending bits and slots cleared; state IDLE; last-served pointer = CHANNELS-1, so ch0 wins first.
  - Reset mid-computation discards the job with no done_o.
- Latency, idle block, no contention: done_o high in the cycle after rising edge 11-octave, counting the edge that sampled req_i as edge 0. Range: 4 (octave 7) to 11 (octave 0).
- Service time per job is 11-octave cycles; DONE always returns through IDLE (no back-to-back bypass).
- Simultaneous requests are served in round-robin order starting after the last-served channel.
- A request arriving in the same cycle as that channel's grant is captured as pending after the grant.

## Configuration
- FREQ_BEND_EN defined:
  - bend_i ports exist; bend is latched with the request.
  - Extra BEND state between SHIFT and DONE: acc = acc + ((acc * bend) >>> 11), signed. This gives roughly ±1 semitone.
  - Overflow saturates to all-ones.
  - Latency becomes 12-octave.
- FREQ_BEND_EN undefined: no bend_i port, no BEND state, no multiplier.

## Structure
- Package freq_pkg:
  - NOTE_TABLE: 12 x 29-bit, C8..B8 in Q13.16 (e.g. A8 = 7040*65536).
  - NOTE_W=4, OCT_W=3, BEND_SHIFT=11.
  - FSM state enum.
- Sub-module rr_arbiter (CHANNELS-wide pending vector plus last-served pointer -> one-hot grant and index). It is the one natural split; the shifter and FSM stay in the top.

## Test plan
- Reset: hold reset=0 while driving requests. All outputs stay 0 and no done_o pulses. Release; the first grant goes to ch0.
- ch0 note=9, octave=4 (A4) -> done_o[0] after edge 7, freq_o[0]=112640 (440.0 Hz), err_o=0.
- Octave extremes on note 9:
  - octave 7 -> 901120 (3520 Hz), latency 4.
  - octave 0 -> 7040 (27.5 Hz), latency 11.
  - C4 (note 0, octave 4) -> 66976.
- All four channels request A4 in the same cycle -> done_o pulses ch0, ch1, ch2, ch3 at edges 7, 14, 21, 28. Each freq_o = 112640.
- Invalid and reset cases:
  - note=13 -> done_o and err_o pulse together, freq_o=0.
  - reset asserted during SHIFT -> no done_o, outputs 0.
- With FREQ_BEND_EN: A4, bend=+127 -> freq_o=119625, latency 8. bend=0 -> 112640.
